icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the fetch stage (PC / instruction port of the MIPS core) and the backing instruction memory.
- A hit returns the instruction combinationally in the same cycle, so a single-cycle or pipelined core can fetch without added latency.
- A miss stalls fetch, then refills the whole block from instruction memory one word per request/valid handshake.
- Default geometry: 4 lines × 4 words. Address split is tag[31:6] / index[5:4] / word[3:2] / byte[1:0].

---
 rtl/icache_pkg.sv | 43 ++++
 rtl/icache_array.sv | 57 +++++
 rtl/icache_dm.sv | 155 +++++++++++++++
 tb/tb_icache_dm.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address-field helpers for the direct-mapped
// instruction cache.
//   state_e    : refill FSM states
//   addr_tag   : tag field of a byte address for a LINES x WORDS geometry
//   addr_idx   : line index field
//   addr_word  : word-in-block field
package icache_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REFILL    = 2'd1,
      FILL_DONE = 2'd2
   } state_e;

   // Ceiling log2 usable on non-constant arguments.
   function automatic int unsigned log2c(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                   input int unsigned lines,
                                                   input int unsigned words);
      return a >> (2 + log2c(words) + log2c(lines));
   endfunction

   function automatic logic [ADDR_W-1:0] addr_idx(input logic [ADDR_W-1:0] a,
                                                   input int unsigned lines,
                                                   input int unsigned words);
      return (a >> (2 + log2c(words))) & (lines - 1);
   endfunction

   function automatic logic [ADDR_W-1:0] addr_word(input logic [ADDR_W-1:0] a,
                                                    input int unsigned words);
      return (a >> 2) & (words - 1);
   endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage of the direct-mapped cache.
//   clk, rst_n          : clock, async active-low reset (valid bits only)
//   i_clear             : invalidate every line (wins over i_set_valid)
//   i_we/i_wr_*         : write one data word; i_tag_we writes the line tag
//   i_set_valid         : mark i_wr_line valid
//   i_rd_line/i_rd_word : combinational read port -> o_rd_valid/tag/data
module icache_array
   import icache_pkg::*;
#(
   parameter  int unsigned LINES = 4,
   parameter  int unsigned WORDS = 4,
   parameter  int unsigned TAG_W = 26,
   localparam int unsigned IDX_W = $clog2(LINES),
   localparam int unsigned WRD_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_wr_line,
   input  logic [WRD_W-1:0]  i_wr_word,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_tag_we,
   input  logic [TAG_W-1:0]  i_wr_tag,
   input  logic              i_set_valid,
   input  logic [IDX_W-1:0]  i_rd_line,
   input  logic [WRD_W-1:0]  i_rd_word,
   output logic              o_rd_valid,
   output logic [TAG_W-1:0]  o_rd_tag,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [DATA_W-1:0] r_data [LINES][WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (i_clear) begin
         r_valid <= '0;
      end else if (i_set_valid) begin
         r_valid[i_wr_line] <= 1'b1;
      end
   end

   // Tag and data need no reset: they are only observed behind a valid bit.
   always_ff @(posedge clk) begin
      if (i_we) r_data[i_wr_line][i_wr_word] <= i_wr_data;
      if (i_tag_we) r_tag[i_wr_line] <= i_wr_tag;
   end

   assign o_rd_valid = r_valid[i_rd_line];
   assign o_rd_tag   = r_tag[i_rd_line];
   assign o_rd_data  = r_data[i_rd_line][i_rd_word];

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache.
//   clk, reset            : clock, async active-low reset
//   cpu_req/cpu_addr      : fetch request and byte address
//   flush                 : invalidate all lines (pulse)
//   cpu_instr/cpu_ready   : same-cycle hit data and hit flag
//   mem_req/mem_addr      : refill beat request (held until mem_valid)
//   mem_rdata/mem_valid   : refill beat data and completion
//   hit_cnt/miss_cnt      : saturating hit / refill counters
module icache_dm
   import icache_pkg::*;
#(
   parameter  int unsigned LINES = 4,
   parameter  int unsigned WORDS = 4,
   localparam int unsigned TAG_W = 32 - 2 - $clog2(WORDS) - $clog2(LINES)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic        flush,
   output logic [31:0] cpu_instr,
   output logic        cpu_ready,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned WRD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] BLK_MASK = ~(32'(WORDS * 4) - 32'd1);

   state_e            r_state, w_state_nxt;
   logic [31:0]       r_base;
   logic [WRD_W-1:0]  r_beat;
   logic              r_flush_pend;
   logic [31:0]       r_hit_cnt, r_miss_cnt;

   logic [IDX_W-1:0]  w_lk_idx, w_rf_idx;
   logic [WRD_W-1:0]  w_lk_word;
   logic [TAG_W-1:0]  w_lk_tag, w_rf_tag;
   logic              w_rd_valid;
   logic [TAG_W-1:0]  w_rd_tag;
   logic [31:0]       w_rd_data;
   logic              w_hit, w_miss_start, w_beat_ack, w_last_beat, w_flush_any;
   logic              w_clear, w_set_valid;

   assign w_lk_idx  = IDX_W'(addr_idx(cpu_addr, LINES, WORDS));
   assign w_lk_word = WRD_W'(addr_word(cpu_addr, WORDS));
   assign w_lk_tag  = TAG_W'(addr_tag(cpu_addr, LINES, WORDS));
   assign w_rf_idx  = IDX_W'(addr_idx(r_base, LINES, WORDS));
   assign w_rf_tag  = TAG_W'(addr_tag(r_base, LINES, WORDS));

   assign w_hit        = cpu_req && w_rd_valid && (w_rd_tag == w_lk_tag) &&
                         (r_state == IDLE) && !flush;
   assign w_miss_start = cpu_req && !w_hit && (r_state == IDLE) && !flush;
   assign w_beat_ack   = (r_state == REFILL) && mem_valid;
   assign w_last_beat  = w_beat_ack && (r_beat == WRD_W'(WORDS - 1));
   // A flush arriving on the final beat must also keep the new line invalid.
   assign w_flush_any  = r_flush_pend || flush;

   icache_array #(
      .LINES (LINES),
      .WORDS (WORDS),
      .TAG_W (TAG_W)
   ) u_array (
      .clk         (clk),
      .rst_n       (reset),
      .i_clear     (w_clear),
      .i_we        (w_beat_ack),
      .i_wr_line   (w_rf_idx),
      .i_wr_word   (r_beat),
      .i_wr_data   (mem_rdata),
      .i_tag_we    (w_last_beat),
      .i_wr_tag    (w_rf_tag),
      .i_set_valid (w_set_valid),
      .i_rd_line   (w_lk_idx),
      .i_rd_word   (w_lk_word),
      .o_rd_valid  (w_rd_valid),
      .o_rd_tag    (w_rd_tag),
      .o_rd_data   (w_rd_data)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:      if (w_miss_start) w_state_nxt = REFILL;
         REFILL:    if (w_last_beat) w_state_nxt = FILL_DONE;
         FILL_DONE: w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   // Outputs and array control.
   always_comb begin
      cpu_ready   = w_hit;
      cpu_instr   = w_hit ? w_rd_data : 32'd0;
      mem_req     = 1'b0;
      mem_addr    = 32'd0;
      w_set_valid = w_last_beat && !w_flush_any;
      w_clear     = 1'b0;
      unique case (r_state)
         IDLE: w_clear = flush;
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = r_base + 32'({r_beat, 2'b00});
            w_clear  = w_last_beat && w_flush_any;
         end
         FILL_DONE: w_clear = w_flush_any;
         default: ;
      endcase
   end

   // Refill datapath and flush bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base       <= 32'd0;
         r_beat       <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (w_miss_start) begin
            r_base <= cpu_addr & BLK_MASK;
            r_beat <= '0;
         end else if (w_beat_ack) begin
            r_beat <= r_beat + 1'b1;
         end
         if (r_state == FILL_DONE)                r_flush_pend <= 1'b0;
         else if (r_state == REFILL && flush)     r_flush_pend <= 1'b1;
      end
   end

   // Saturating statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF))         r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (w_miss_start && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = 32'd0;
   logic        flush = 1'b0;
   logic [31:0] cpu_instr;
   logic        cpu_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic [31:0] hit_cnt, miss_cnt;

   // Memory model: word at A holds A ^ 0xA5A5_0000.
   bit          zw = 1'b0;          // zero-wait mode
   bit          force_valid = 1'b0; // stray beat injection
   logic        r_mv = 1'b0;
   logic [31:0] r_rd = 32'd0;
   int          mcnt = 0;

   int checks = 0;
   int errors = 0;

   bit          ref_valid [4];
   logic [31:0] ref_blk [4];
   logic [31:0] exp_hits = 0;
   logic [31:0] exp_miss = 0;
   logic [31:0] beats [$];

   always #5 clk = ~clk;

   assign mem_valid = zw ? mem_req : (r_mv | force_valid);
   assign mem_rdata = zw ? (mem_addr ^ 32'hA5A5_0000) : r_rd;

   icache_dm dut (
      .clk       (clk),
      .reset     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .flush     (flush),
      .cpu_instr (cpu_instr),
      .cpu_ready (cpu_ready),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   // Two-cycle memory: mem_valid pulses two cycles after each visible request.
   always @(posedge clk) begin
      #1;
      if (mem_req !== 1'b1) begin
         r_mv = 1'b0;
         mcnt = 0;
      end else if (r_mv) begin
         r_mv = 1'b0;
         mcnt = 1;
      end else begin
         mcnt++;
         if (mcnt >= 2) begin
            r_mv = 1'b1;
            r_rd = mem_addr ^ 32'hA5A5_0000;
            mcnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mem_req === 1'b1 && mem_valid === 1'b1) beats.push_back(mem_addr);
   end

   function automatic int ref_idx(input logic [31:0] a);
      return int'((a >> 4) & 32'd3);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return ref_valid[ref_idx(a)] && (ref_blk[ref_idx(a)] == (a >> 4));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] a, output int lat);
      bit          eh, got, ok;
      logic [31:0] blk, exp_i;
      eh    = model_hit(a);
      blk   = a & 32'hFFFF_FFF0;
      exp_i = (a & 32'hFFFF_FFFC) ^ 32'hA5A5_0000;
      beats.delete();
      got = 1'b0;
      lat = 0;
      @(posedge clk); #2;
      cpu_req  = 1'b1;
      cpu_addr = a;
      for (int c = 0; c < 64 && !got; c++) begin
         if (c > 0) begin @(posedge clk); #2; end
         @(negedge clk);
         if (cpu_ready === 1'b1) got = 1'b1;
         else lat++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL fetch_timeout addr=%h ready=%b required ready=1", a, cpu_ready);
      end else begin
         checks++;
         if (cpu_instr !== exp_i) begin
            errors++;
            $display("FAIL fetch_instr addr=%h got=%h exp=%h", a, cpu_instr, exp_i);
         end
      end
      checks++;
      if ((eh && lat != 0) || (!eh && lat == 0)) begin
         errors++;
         $display("FAIL hit_class addr=%h stall_cycles=%0d exp_hit=%0d", a, lat, eh);
      end
      ok = eh ? (beats.size() == 0) : (beats.size() == 4);
      if (ok && !eh)
         for (int k = 0; k < 4; k++) if (beats[k] !== blk + 32'(4 * k)) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL refill_beats addr=%h got %0d beats first=%h exp %0d beats from %h",
                  a, beats.size(), (beats.size() > 0) ? beats[0] : 32'hx, eh ? 0 : 4, blk);
      end
      @(posedge clk); #2;
      cpu_req = 1'b0;
      if (!eh) begin
         exp_miss++;
         ref_valid[ref_idx(a)] = 1'b1;
         ref_blk[ref_idx(a)]   = a >> 4;
      end
      if (got) exp_hits++;
      @(negedge clk);
      checks++;
      if (hit_cnt !== exp_hits || miss_cnt !== exp_miss) begin
         errors++;
         $display("FAIL counters hit=%0d miss=%0d exp hit=%0d miss=%0d",
                  hit_cnt, miss_cnt, exp_hits, exp_miss);
      end
   endtask

   task automatic wait_beats(input int n, input string tag);
      int c;
      c = 0;
      while (beats.size() < n && c < 60) begin @(negedge clk); c++; end
      if (beats.size() < n) begin
         checks++;
         errors++;
         $display("FAIL %s_wait beats=%0d required=%0d", tag, beats.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (cpu_ready !== 1'b0 || cpu_instr !== 32'd0 || mem_req !== 1'b0 ||
          mem_addr !== 32'd0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_state ready=%b instr=%h mreq=%b maddr=%h hits=%0d miss=%0d exp all 0",
                  cpu_ready, cpu_instr, mem_req, mem_addr, hit_cnt, miss_cnt);
      end
      model_clear();
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   task automatic test_first_fill();
      int lat;
      do_fetch(32'h0, lat);
      checks++;
      if (miss_cnt !== 32'd1) begin
         errors++;
         $display("FAIL first_miss_cnt got=%0d exp=1", miss_cnt);
      end
   endtask

   task automatic test_sequential();
      int lat;
      logic [31:0] h0;
      h0 = hit_cnt;
      do_fetch(32'h4, lat);
      do_fetch(32'h8, lat);
      do_fetch(32'hC, lat);
      checks++;
      if (hit_cnt !== h0 + 32'd3) begin
         errors++;
         $display("FAIL seq_hits got=%0d exp=%0d", hit_cnt, h0 + 32'd3);
      end
   endtask

   task automatic test_conflict();
      int lat;
      do_fetch(32'h40, lat);
      do_fetch(32'h0, lat);
      checks++;
      if (miss_cnt !== 32'd3) begin
         errors++;
         $display("FAIL conflict_miss_cnt got=%0d exp=3", miss_cnt);
      end
   endtask

   task automatic test_miss_penalty();
      int lat;
      zw = 1'b1;
      do_fetch(32'h84, lat);
      checks++;
      if (lat != 6) begin
         errors++;
         $display("FAIL zero_wait_penalty got=%0d cycles exp=6", lat);
      end
      zw = 1'b0;
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] a;
      for (int i = 0; i < 30; i++) begin
         a = 32'($urandom_range(0, 11) * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
         do_fetch(a, lat);
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #2;
            cpu_addr = $urandom;
            @(negedge clk);
            checks++;
            if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin
               errors++;
               $display("FAIL idle_no_req ready=%b mreq=%b exp 0 0", cpu_ready, mem_req);
            end
         end
      end
   endtask

   task automatic test_flush_idle();
      int lat;
      do_fetch(32'h0, lat);
      do_fetch(32'h4, lat);
      @(posedge clk); #2;
      cpu_req  = 1'b1;
      cpu_addr = 32'h4;
      flush    = 1'b1;
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b0 || cpu_instr !== 32'd0) begin
         errors++;
         $display("FAIL flush_idle_ready ready=%b instr=%h exp 0 0", cpu_ready, cpu_instr);
      end
      @(posedge clk); #2;
      flush   = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || miss_cnt !== exp_miss) begin
         errors++;
         $display("FAIL flush_idle_nomiss mreq=%b miss=%0d exp 0 %0d", mem_req, miss_cnt, exp_miss);
      end
      model_clear();
      do_fetch(32'h4, lat);
   endtask

   task automatic test_flush_refill();
      int lat, c;
      beats.delete();
      @(posedge clk); #2;
      cpu_req  = 1'b1;
      cpu_addr = 32'h10;
      @(posedge clk); #2;
      cpu_req = 1'b0;
      exp_miss++;
      wait_beats(1, "flush_refill");
      @(posedge clk); #2;
      flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
      c = 0;
      while (mem_req === 1'b1 && c < 60) begin @(negedge clk); c++; end
      checks++;
      if (beats.size() != 4 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_refill_done beats=%0d mreq=%b exp 4 0", beats.size(), mem_req);
      end
      model_clear();
      repeat (2) @(posedge clk);
      do_fetch(32'h10, lat);
      do_fetch(32'h4, lat);
   endtask

   task automatic test_reset_mid_refill();
      int lat;
      beats.delete();
      @(posedge clk); #2;
      cpu_req  = 1'b1;
      cpu_addr = 32'h200;
      @(posedge clk); #2;
      cpu_req = 1'b0;
      wait_beats(1, "reset_mid");
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'd0 || cpu_ready !== 1'b0 ||
          hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_refill mreq=%b maddr=%h ready=%b hits=%0d miss=%0d exp all 0",
                  mem_req, mem_addr, cpu_ready, hit_cnt, miss_cnt);
      end
      model_clear();
      exp_hits = 0;
      exp_miss = 0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      beats.delete();
      force_valid = 1'b1;
      repeat (2) begin @(posedge clk); #2; end
      force_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || beats.size() != 0 || miss_cnt !== 32'd0) begin
         errors++;
         $display("FAIL stale_valid mreq=%b beats=%0d miss=%0d exp 0 0 0",
                  mem_req, beats.size(), miss_cnt);
      end
      do_fetch(32'h0, lat);
   endtask

   initial begin
      test_reset();
      test_first_fill();
      test_sequential();
      test_conflict();
      test_miss_penalty();
      test_random();
      test_flush_idle();
      test_flush_refill();
      test_reset_mid_refill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
